// File: rtl/board_mem_arbiter.sv
// Two-port arbiter (display reads, game-logic reads/writes) in front of a single board memory.
// Define BOARD_INIT_EN to add a power-up sequence that writes the chess start position.
module board_mem_arbiter #(
   parameter int ADDR_W  = 6,
   parameter int PIECE_W = 4
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               disp_req,
   input  logic [ADDR_W-1:0]  disp_addr,
   output logic               disp_ack,
   output logic [PIECE_W-1:0] disp_data,
   input  logic               gl_req,
   input  logic               gl_we,
   input  logic [ADDR_W-1:0]  gl_addr,
   input  logic [PIECE_W-1:0] gl_wdata,
   output logic               gl_ack,
   output logic [PIECE_W-1:0] gl_rdata,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_we,
   output logic [PIECE_W-1:0] mem_wdata,
   input  logic [PIECE_W-1:0] mem_rdata,
   output logic               busy
);

`ifdef BOARD_INIT_EN
   localparam logic [1:0] ST_INIT   = 2'd0;
`endif
   localparam logic [1:0] ST_IDLE   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   localparam logic GRANT_DISP = 1'b0;
   localparam logic GRANT_GL   = 1'b1;

   logic [1:0]         r_state;
   logic               r_last_grant;
   logic               r_win_gl;
   logic               r_disp_ack;
   logic               r_gl_ack;
   logic [PIECE_W-1:0] r_disp_data;
   logic [PIECE_W-1:0] r_gl_rdata;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic               r_mem_we;
   logic [PIECE_W-1:0] r_mem_wdata;

   logic w_disp_elig;
   logic w_gl_elig;
   logic w_pick_gl;

   // A requester still showing its ack is ignored so a held request is served once.
   assign w_disp_elig = disp_req && !r_disp_ack;
   assign w_gl_elig   = gl_req && !r_gl_ack;
   assign w_pick_gl   = w_gl_elig && (!w_disp_elig || (r_last_grant == GRANT_DISP));

`ifdef BOARD_INIT_EN
   logic [ADDR_W-1:0] r_ptr;
   logic              r_busy;

   function automatic logic [PIECE_W-1:0] f_start_piece(input logic [ADDR_W-1:0] ptr);
      logic [2:0] back_type;
      case (ptr[2:0])
         3'd0, 3'd7: back_type = 3'd4;
         3'd1, 3'd6: back_type = 3'd2;
         3'd2, 3'd5: back_type = 3'd3;
         3'd3:       back_type = 3'd5;
         default:    back_type = 3'd6;
      endcase
      case (ptr[5:3])
         3'd0:    f_start_piece = {1'b1, back_type};
         3'd1:    f_start_piece = 4'b1001;
         3'd6:    f_start_piece = 4'b0001;
         3'd7:    f_start_piece = {1'b0, back_type};
         default: f_start_piece = 4'b0000;
      endcase
   endfunction

   assign busy = r_busy;
`else
   assign busy = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
`ifdef BOARD_INIT_EN
         r_state <= ST_INIT;
         r_ptr   <= '0;
         r_busy  <= 1'b1;
`else
         r_state <= ST_IDLE;
`endif
         r_last_grant <= GRANT_GL;
         r_win_gl     <= 1'b0;
         r_disp_ack   <= 1'b0;
         r_gl_ack     <= 1'b0;
         r_disp_data  <= '0;
         r_gl_rdata   <= '0;
         r_mem_addr   <= '0;
         r_mem_we     <= 1'b0;
         r_mem_wdata  <= '0;
      end else begin
         r_disp_ack <= 1'b0;
         r_gl_ack   <= 1'b0;
         case (r_state)
`ifdef BOARD_INIT_EN
            ST_INIT: begin
               r_mem_we    <= 1'b1;
               r_mem_addr  <= r_ptr;
               r_mem_wdata <= f_start_piece(r_ptr);
               if (r_ptr == '1) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end
`endif
            ST_IDLE: begin
               r_mem_we <= 1'b0;
               if (w_disp_elig || w_gl_elig) begin
                  r_win_gl     <= w_pick_gl;
                  r_last_grant <= w_pick_gl ? GRANT_GL : GRANT_DISP;
                  r_mem_addr   <= w_pick_gl ? gl_addr : disp_addr;
                  r_mem_we     <= w_pick_gl && gl_we;
                  if (w_pick_gl) begin
                     r_mem_wdata <= gl_wdata;
                  end
                  r_state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               // r_mem_we still marks whether the access in flight is a write.
               r_mem_we <= 1'b0;
               if (r_win_gl) begin
                  r_gl_ack <= 1'b1;
                  if (!r_mem_we) begin
                     r_gl_rdata <= mem_rdata;
                  end
               end else begin
                  r_disp_ack  <= 1'b1;
                  r_disp_data <= mem_rdata;
               end
               r_state <= ST_IDLE;
            end
            default: begin
               r_mem_we <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign disp_ack  = r_disp_ack;
   assign disp_data = r_disp_data;
   assign gl_ack    = r_gl_ack;
   assign gl_rdata  = r_gl_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a behavioural board memory (async read, sync write).
module tb_board_mem_arbiter;
   localparam int ADDR_W  = 6;
   localparam int PIECE_W = 4;
`ifdef BOARD_INIT_EN
   localparam logic EXP_BUSY_RST = 1'b1;
   localparam logic [3:0] EXP_ADDR5 = 4'b1011;
`else
   localparam logic EXP_BUSY_RST = 1'b0;
   localparam logic [3:0] EXP_ADDR5 = 4'b0011;
`endif

   logic               CLK = 1'b0;
   logic               RESET = 1'b1;
   logic               disp_req = 1'b0;
   logic [ADDR_W-1:0]  disp_addr = '0;
   logic               disp_ack;
   logic [PIECE_W-1:0] disp_data;
   logic               gl_req = 1'b0;
   logic               gl_we = 1'b0;
   logic [ADDR_W-1:0]  gl_addr = '0;
   logic [PIECE_W-1:0] gl_wdata = '0;
   logic               gl_ack;
   logic [PIECE_W-1:0] gl_rdata;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_we;
   logic [PIECE_W-1:0] mem_wdata;
   logic [PIECE_W-1:0] mem_rdata;
   logic               busy;

   logic [PIECE_W-1:0] mem_model [0:63];
   logic               pl_en = 1'b0;
   logic [ADDR_W-1:0]  pl_addr = '0;
   logic [PIECE_W-1:0] pl_data = '0;
   logic               busy_seen = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   board_mem_arbiter #(.ADDR_W(ADDR_W), .PIECE_W(PIECE_W)) dut (
      .CLK(CLK), .RESET(RESET),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_data(disp_data),
      .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
      .gl_ack(gl_ack), .gl_rdata(gl_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   assign mem_rdata = mem_model[mem_addr];
   always @(posedge CLK) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else if (pl_en) mem_model[pl_addr] <= pl_data;
   end
   always @(posedge CLK) if (busy) busy_seen <= 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [5:0] a, input logic [3:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge CLK); #1;
      pl_en = 1'b0;
      $display("preload addr=%0d data=%b", a, d);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (busy && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      check("wait_ready", busy, 0);
      @(posedge CLK); #1;
   endtask

   task automatic pulse_reset();
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      $display("reset pulse");
   endtask

   task automatic gl_access(input logic we, input logic [5:0] a, input logic [3:0] d,
                            input logic [3:0] exp_rdata);
      gl_req = 1'b1; gl_we = we; gl_addr = a; gl_wdata = d;
      @(posedge CLK); #1;
      check("gl_access_we", mem_we, we);
      check("gl_access_addr", mem_addr, a);
      check("gl_early_ack", gl_ack, 0);
      @(posedge CLK); #1;
      check("gl_ack", gl_ack, 1);
      check("gl_we_drop", mem_we, 0);
      check("gl_rdata", gl_rdata, exp_rdata);
      gl_req = 1'b0;
      $display("gl %s addr=%0d wdata=%b rdata=%b", we ? "wr" : "rd", a, d, gl_rdata);
      @(posedge CLK); #1;
      check("gl_ack_pulse", gl_ack, 0);
   endtask

   task automatic disp_access(input logic [5:0] a, input logic [3:0] exp_data,
                              input logic [3:0] exp_gl);
      disp_req = 1'b1; disp_addr = a;
      @(posedge CLK); #1;
      check("disp_access_we", mem_we, 0);
      check("disp_access_addr", mem_addr, a);
      @(posedge CLK); #1;
      check("disp_ack", disp_ack, 1);
      check("disp_data", disp_data, exp_data);
      check("disp_gl_rdata_kept", gl_rdata, exp_gl);
      disp_req = 1'b0;
      $display("disp rd addr=%0d data=%b", a, disp_data);
      @(posedge CLK); #1;
      check("disp_ack_pulse", disp_ack, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp_acks [0:7];
      exp_acks = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

      repeat (3) @(posedge CLK);
      #1;
      check("rst_disp_ack", disp_ack, 0);
      check("rst_gl_ack", gl_ack, 0);
      check("rst_disp_data", disp_data, 0);
      check("rst_gl_rdata", gl_rdata, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_busy", busy, EXP_BUSY_RST);
      RESET = 1'b0;

`ifdef BOARD_INIT_EN
      begin
         int nwr = 0;
         int cyc = 0;
         while (busy && cyc < 200) begin
            @(posedge CLK); #1;
            cyc++;
            if (mem_we) nwr++;
         end
         check("init_writes", nwr, 64);
         check("init_busy_done", busy, 0);
         @(posedge CLK); #1;
         check("init_addr0", mem_model[0], 4'b1100);
         check("init_addr9", mem_model[9], 4'b1001);
         check("init_addr60", mem_model[60], 4'b0110);
         check("init_addr63", mem_model[63], 4'b0100);
         $display("init sequence writes=%0d", nwr);
      end
`endif

      // Write then read back through the game-logic port.
      gl_access(1'b1, 6'd20, 4'b0101, 4'b0000);
      check("mem_addr20", mem_model[20], 4'b0101);
      gl_access(1'b0, 6'd20, 4'b0000, 4'b0101);
      gl_access(1'b1, 6'd21, 4'b0111, 4'b0101);
      disp_access(6'd21, 4'b0111, 4'b0101);

      // Both requesters held: display wins the first tie after reset, then strict alternation.
      pulse_reset();
      wait_ready();
      preload(6'd3, 4'b1010);
      preload(6'd4, 4'b0110);
      disp_req = 1'b1; disp_addr = 6'd3;
      gl_req = 1'b1; gl_we = 1'b0; gl_addr = 6'd4;
      for (int i = 0; i < 8; i++) begin
         @(posedge CLK); #1;
         check($sformatf("alt_disp_ack%0d", i), disp_ack, exp_acks[i][1]);
         check($sformatf("alt_gl_ack%0d", i), gl_ack, exp_acks[i][0]);
         $display("alt cycle %0d disp_ack=%b gl_ack=%b", i, disp_ack, gl_ack);
      end
      disp_req = 1'b0; gl_req = 1'b0;
      check("alt_disp_data", disp_data, 4'b1010);
      check("alt_gl_rdata", gl_rdata, 4'b0110);

      // Reset landing in the ACCESS cycle of a write.
      @(posedge CLK); #1;
      gl_req = 1'b1; gl_we = 1'b1; gl_addr = 6'd30; gl_wdata = 4'b1111;
      @(posedge CLK); #1;
      check("rst_mid_we", mem_we, 1);
      RESET = 1'b1;
      @(posedge CLK); #1;
      check("rst_mid_no_ack", gl_ack, 0);
      check("rst_mid_we_drop", mem_we, 0);
      check("rst_mid_busy", busy, EXP_BUSY_RST);
      gl_req = 1'b0; RESET = 1'b0;
      $display("reset during gl write addr=30");
      @(posedge CLK); #1;
      check("rst_mid_no_late_ack", gl_ack, 0);
      wait_ready();

      // Memory contents survive reset unless the init sequence rewrites them.
      preload(6'd5, 4'b0011);
      pulse_reset();
      wait_ready();
      disp_access(6'd5, EXP_ADDR5, 4'b0000);
`ifndef BOARD_INIT_EN
      check("busy_never_high", busy_seen, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/board_mem_arbiter.md
BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6; square address width, {row[2:0], col[2:0]}.
REQ-002 Parameter PIECE_W, default 4; piece code width, {color, type[2:0]}.
REQ-003 CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 disp_req  in  1  display read request; held high until disp_ack.
REQ-006 disp_addr  in  ADDR_W  display read address; stable while disp_req is high.
REQ-007 disp_ack  out  1  one-cycle pulse; disp_data is valid in the same cycle.
REQ-008 disp_data  out  PIECE_W  registered piece read for the display.
REQ-009 gl_req  in  1  game-logic request; held high until gl_ack.
REQ-010 gl_we  in  1  1 = write, 0 = read; stable while gl_req is high.
REQ-011 gl_addr  in  ADDR_W  game-logic address.
REQ-012 gl_wdata  in  PIECE_W  game-logic write data.
REQ-013 gl_ack  out  1  one-cycle completion pulse, for both reads and writes.
REQ-014 gl_rdata  out  PIECE_W  registered read data; left unchanged by writes.
REQ-015 mem_addr  out  ADDR_W  board memory address, registered.
REQ-016 mem_we  out  1  board memory write strobe, registered.
REQ-017 mem_wdata  out  PIECE_W  board memory write data, registered.
REQ-018 mem_rdata  in  PIECE_W  board memory asynchronous read data for mem_addr.
REQ-019 busy  out  1  high while the init sequence runs.

Function
REQ-020 The FSM SHALL have states INIT, IDLE and ACCESS.
REQ-021 IDLE: on any eligible request at an edge, the arbiter SHALL latch the winner, drive mem_addr/mem_we/mem_wdata and enter ACCESS.
REQ-022 ACCESS lasts exactly one cycle: mem_we = 1 only for a gl write; at its closing edge mem_rdata is captured, the winner's ack is set and the FSM returns to IDLE.
REQ-023 Latency: req sampled at edge E -> ack and data high during the cycle after edge E+1; peak throughput is one access per 2 cycles.
REQ-024 mem_we SHALL deassert at the edge that ends ACCESS, so it is never high for more than one cycle per write.
REQ-025 A requester whose ack is high in a cycle is not eligible that cycle, so a held req is not double-served.
REQ-026 Tie (both eligible) SHALL go to the requester not granted last (round-robin via last_grant); a single eligible requester always wins.
REQ-027 Display accesses are reads only: mem_we = 0 and gl_rdata untouched.
REQ-028 disp_data and gl_rdata SHALL hold their last values between acks.
REQ-029 Request changes during ACCESS SHALL not affect the access in flight.

Reset
REQ-030 RESET at any cycle, including mid-ACCESS, SHALL drop the in-flight access with no ack issued.
REQ-031 Reset values: disp_ack=0, gl_ack=0, disp_data=0, gl_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset values (continued): last_grant=gl, so the display wins the first tie.
REQ-033 Exit state: INIT with busy=1 when BOARD_INIT_EN is defined; otherwise IDLE with busy=0.

Configuration
REQ-034 Macro BOARD_INIT_EN defined: INIT runs 64 cycles with ptr 0..63.
REQ-035 INIT write strobe: mem_we=1, mem_addr=ptr, mem_wdata=start piece for ptr.
REQ-036 Start pieces, rows 0 and 1: row0 = 1 followed by back rank 4,2,3,5,6,3,2,4; row1 = 4'b1001.
REQ-037 Start pieces, rows 2-7: rows 2-5 = 4'b0000; row6 = 4'b0001; row7 = 0 followed by back rank.
REQ-038 INIT requests: none acked; they SHALL be served normally after INIT -> IDLE following ptr=63.
REQ-039 INIT end: busy falls on the same edge as INIT -> IDLE.
REQ-040 Macro absent: no INIT state or ptr logic, busy tied 0, memory contents untouched by reset.

Verification
REQ-041 EN, release RESET -> 64 consecutive writes; addr 0 gets 4'b1100, addr 9 gets 4'b1001, addr 60 gets 4'b0110; busy=0 after write 64.
REQ-042 gl write addr 20 data 4'b0101, then gl read addr 20 -> first gl_ack with mem_we pulse, second gl_ack with gl_rdata=4'b0101; each ack 2 cycles after its req.
REQ-043 disp_req and gl_req held high together for 8 cycles -> acks alternate disp, gl, disp, gl; never two acks in one cycle.
REQ-044 RESET asserted in the ACCESS cycle of a gl write -> no gl_ack, mem_we=0 next cycle, FSM in INIT/IDLE.
REQ-045 Macro absent, preload addr 5 = 4'b0011, pulse RESET, display read addr 5 -> disp_data=4'b0011, busy never high.
